// File: rtl/datapath_sequencer.sv
// Command-driven control sequencer for the regfile/ALU/data-memory datapath.
// Accepts one NOP/STORE/LOAD command at a time and issues registered strobes for it.
module datapath_sequencer #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_ra,
    input  logic [4:0] cmd_rb,
    input  logic [4:0] cmd_alu,
    output logic [4:0] r1,
    output logic [4:0] r2,
    output logic [4:0] ALUc,
    output logic       regw,
    output logic       memw,
    output logic       memr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // state | meaning
    // IDLE  | waiting for a command; done pulses here after completion
    // ST    | memory write cycle (memw)
    // RD    | memory read latency, MEM_LAT cycles (memr)
    // WB    | register writeback of memory data (memr, regw)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST   = 2'd1,
        RD   = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lat_cnt;
    logic [3:0] lat_cnt_nxt;
    logic       done_nxt;
    logic       err_nxt;
    logic       accept;

    assign cmd_ready = (state == IDLE) & reset;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        done_nxt    = 1'b0;
        err_nxt     = err;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: begin
                            done_nxt = 1'b1;
                        end
                        OP_STORE: begin
                            state_nxt = ST;
                        end
                        OP_LOAD: begin
                            state_nxt   = RD;
                            lat_cnt_nxt = LAT_INIT;
                        end
                        default: begin
                            done_nxt = 1'b1;
                            err_nxt  = 1'b1;
                        end
                    endcase
                end
            end
            ST: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            RD: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = WB;
                end else begin
                    lat_cnt_nxt = lat_cnt - 4'd1;
                end
            end
            WB: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they come straight out of flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
            r1      <= 5'd0;
            r2      <= 5'd0;
            ALUc    <= 5'd0;
            regw    <= 1'b0;
            memw    <= 1'b0;
            memr    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            busy    <= (state_nxt != IDLE);
            memw    <= (state_nxt == ST);
            memr    <= (state_nxt == RD) || (state_nxt == WB);
            regw    <= (state_nxt == WB);
            if (accept) begin
                r1   <= cmd_ra;
                r2   <= cmd_rb;
                ALUc <= cmd_alu;
            end
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a small behavioural regfile/memory harness driven by the
// DUT strobes, plus a command-level reference that predicts strobe windows and final contents.
module tb_datapath_sequencer;

    localparam int unsigned LAT = 3;

    localparam logic [4:0] W_ST   = 5'b11000;  // {busy,memw,memr,regw,done}
    localparam logic [4:0] W_RD   = 5'b10100;
    localparam logic [4:0] W_WB   = 5'b10110;
    localparam logic [4:0] W_DONE = 5'b00001;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_ra;
    logic [4:0] cmd_rb;
    logic [4:0] cmd_alu;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] ALUc;
    logic       regw;
    logic       memw;
    logic       memr;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    datapath_sequencer #(.MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_alu   (cmd_alu),
        .r1        (r1),
        .r2        (r2),
        .ALUc      (ALUc),
        .regw      (regw),
        .memw      (memw),
        .memr      (memr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] hrf[32];
    logic [15:0] hmem[256];
    logic [15:0] ref_rf[32];
    logic [15:0] ref_mem[256];

    logic [4:0] sched[$];
    logic [4:0] cur = 5'd0;
    logic       err_m = 1'b0;
    logic [4:0] m_ra = 5'd0;
    logic [4:0] m_rb = 5'd0;
    logic [4:0] m_alu = 5'd0;
    logic       last_acc = 1'b0;

    int cnt_memw, cnt_memr, cnt_regw, cnt_done, cnt_notready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] alu_f(input logic [4:0] c, input logic [15:0] a,
                                          input logic [15:0] b);
        case (c)
            5'd0:    return a;
            5'd1:    return a + b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic clear_counts();
        cnt_memw = 0; cnt_memr = 0; cnt_regw = 0; cnt_done = 0; cnt_notready = 0;
    endtask

    // One clock: datapath harness reacts to pre-edge strobes, reference advances, outputs compared.
    task automatic step();
        logic        acc;
        logic        h_mw;
        logic        h_rw;
        logic [15:0] res;
        logic [15:0] mres;
        logic [7:0]  h_addr;
        logic [4:0]  h_r2;
        logic [15:0] h_wd;
        logic [21:0] exp_v;
        logic [21:0] got_v;
        acc    = cmd_valid && reset && !cur[4];
        h_mw   = memw;
        h_rw   = regw;
        res    = alu_f(ALUc, hrf[r1], hrf[r2]);
        h_addr = res[7:0];
        h_r2   = r2;
        h_wd   = hrf[r2];
        @(posedge clk);
        if (h_mw) hmem[h_addr] = h_wd;
        if (h_rw) hrf[h_r2] = hmem[h_addr];
        if (!reset) begin
            sched.delete();
            cur   = 5'd0;
            err_m = 1'b0;
            m_ra  = 5'd0;
            m_rb  = 5'd0;
            m_alu = 5'd0;
        end else begin
            mres = alu_f(m_alu, ref_rf[m_ra], ref_rf[m_rb]);
            if (cur[3]) ref_mem[mres[7:0]] = ref_rf[m_rb];
            if (cur[1]) ref_rf[m_rb] = ref_mem[mres[7:0]];
            cur = (sched.size() > 0) ? sched.pop_front() : 5'd0;
            if (acc) begin
                m_ra  = cmd_ra;
                m_rb  = cmd_rb;
                m_alu = cmd_alu;
                case (cmd_op)
                    2'b00: sched.push_back(W_DONE);
                    2'b01: begin
                        sched.push_back(W_ST);
                        sched.push_back(W_DONE);
                    end
                    2'b10: begin
                        for (int k = 0; k < int'(LAT); k++) sched.push_back(W_RD);
                        sched.push_back(W_WB);
                        sched.push_back(W_DONE);
                    end
                    default: begin
                        sched.push_back(W_DONE);
                        err_m = 1'b1;
                    end
                endcase
                cur = sched.pop_front();
            end
        end
        last_acc = acc;
        #1;
        exp_v = {reset && !cur[4], cur, err_m, m_ra, m_rb, m_alu};
        got_v = {cmd_ready, busy, memw, memr, regw, done, err, r1, r2, ALUc};
        check("cycle", 32'(got_v), 32'(exp_v));
        if (reset) begin
            if (memw) cnt_memw++;
            if (memr) cnt_memr++;
            if (regw) cnt_regw++;
            if (done) cnt_done++;
            if (!cmd_ready) cnt_notready++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] alu, output int waits);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_alu   = alu;
        waits     = 0;
        do begin
            step();
            waits++;
        end while (!last_acc && waits < 20);
        if (!last_acc) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w2;
        logic [15:0] rf9_before;
        for (int i = 0; i < 32; i++) begin
            hrf[i]    = 16'($urandom);
            ref_rf[i] = hrf[i];
        end
        for (int i = 0; i < 256; i++) begin
            hmem[i]    = 16'($urandom);
            ref_mem[i] = hmem[i];
        end
        hrf[5] = 16'h0010; ref_rf[5] = 16'h0010;
        hrf[6] = 16'h00AB; ref_rf[6] = 16'h00AB;
        hmem[8'h10] = 16'h1234; ref_mem[8'h10] = 16'h1234;

        reset = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b01;
        cmd_ra = 5'd5; cmd_rb = 5'd6; cmd_alu = 5'd0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'd1);
        idle(1);

        clear_counts();
        issue(2'b10, 5'd5, 5'd7, 5'd0, w);
        idle(LAT + 2);
        check("load_rf7", 32'(hrf[7]), 32'h1234);
        check("load_memr_cycles", 32'(cnt_memr), 32'(LAT + 1));
        check("load_regw_cycles", 32'(cnt_regw), 32'd1);
        check("load_done_pulses", 32'(cnt_done), 32'd1);

        clear_counts();
        issue(2'b01, 5'd5, 5'd6, 5'd0, w);
        idle(3);
        check("store_mem10", 32'(hmem[8'h10]), 32'h00AB);
        check("store_memw_cycles", 32'(cnt_memw), 32'd1);
        check("store_done_pulses", 32'(cnt_done), 32'd1);
        check("store_notready_cycles", 32'(cnt_notready), 32'd1);

        clear_counts();
        issue(2'b01, 5'd5, 5'd6, 5'd0, w);
        issue(2'b10, 5'd5, 5'd8, 5'd0, w2);
        check("b2b_accept_wait", 32'(w2), 32'd2);
        idle(LAT + 3);
        check("b2b_rf8", 32'(hrf[8]), 32'h00AB);
        check("b2b_done_pulses", 32'(cnt_done), 32'd2);

        clear_counts();
        issue(2'b11, 5'd1, 5'd2, 5'd3, w);
        idle(2);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_strobes", 32'(cnt_memw + cnt_memr + cnt_regw), 32'd0);
        check("illegal_done", 32'(cnt_done), 32'd1);
        issue(2'b00, 5'd4, 5'd5, 5'd6, w);
        idle(2);
        check("nop_err_sticky", 32'(err), 32'd1);
        check("nop_done", 32'(cnt_done), 32'd2);

        rf9_before = ref_rf[9];
        issue(2'b10, 5'd5, 5'd9, 5'd0, w);
        cmd_valid = 1'b0;
        step();
        reset = 1'b0;
        clear_counts();
        step();
        check("rst_mid_memr", 32'(memr), 32'd0);
        check("rst_mid_regw", 32'(regw), 32'd0);
        reset = 1'b1;
        idle(LAT + 3);
        check("rst_mid_no_done", 32'(cnt_done), 32'd0);
        check("rst_mid_rf9", 32'(hrf[9]), 32'(rf9_before));
        check("rst_mid_err_cleared", 32'(err), 32'd0);

        for (int i = 0; i < 2500; i++) begin
            if (!cmd_valid || last_acc) begin
                cmd_valid = ($urandom % 3) != 0;
                cmd_op    = 2'($urandom);
                cmd_ra    = 5'($urandom);
                cmd_rb    = 5'($urandom);
                cmd_alu   = 5'($urandom % 3);
            end
            reset = !((($urandom % 60) == 0) && !cur[3] && !cur[1]);
            step();
        end
        reset = 1'b1;
        idle(LAT + 3);
        for (int i = 0; i < 32; i++) check("final_rf", 32'(hrf[i]), 32'(ref_rf[i]));
        for (int i = 0; i < 256; i++) check("final_mem", 32'(hmem[i]), 32'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
